hash_learn: RTL and testbench

//  Requester-side engine for the hash table block: drives its key/value/add/update/del/req

---
 rtl/hash_learn_pkg.sv | 12 +
 rtl/hash_learn_if.sv | 47 ++++
 rtl/hash_learn_tick.sv | 29 ++
 rtl/hash_learn.sv | 169 ++++++++++++++++
 tb/tb_hash_learn.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_learn_pkg.sv
// Shared types for the hash-table learning engine: FSM state encoding.
package hash_learn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_LEARN  = 3'd2,
    ST_OUT    = 3'd3,
    ST_DEL    = 3'd4
  } state_t;

endpackage

// File: rtl/hash_learn_if.sv
// Record, result, management-delete and table-request signals of the learning engine.
// Handshakes: in_valid/in_ready and out_valid/out_ready transfer on a clock edge where
// both are high; valid is held with stable data until that edge. del_req and h_req are
// held until their one-cycle ack pulse (del_ack / h_ack).
interface hash_learn_if #(
  parameter int KEYWIDTH   = 20,
  parameter int VALUEWIDTH = 2
);
  logic [KEYWIDTH-1:0]   in_src;
  logic [KEYWIDTH-1:0]   in_dst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_found;
  logic [VALUEWIDTH-1:0] out_value;
  logic                  out_new;
  logic                  out_valid;
  logic                  out_ready;
  logic [KEYWIDTH-1:0]   del_key;
  logic                  del_req;
  logic                  del_ack;
  logic                  del_found;
  logic [KEYWIDTH-1:0]   h_key;
  logic [VALUEWIDTH-1:0] h_value;
  logic                  h_add;
  logic                  h_update;
  logic                  h_del;
  logic                  h_req;
  logic                  h_ack;
  logic                  h_found;
  logic [VALUEWIDTH-1:0] h_found_value;
  logic                  h_ovf;

  // Engine side: requester toward the table, responder toward parser/management.
  modport master (
    input  in_src, in_dst, in_valid, out_ready, del_key, del_req,
           h_ack, h_found, h_found_value, h_ovf,
    output in_ready, out_found, out_value, out_new, out_valid, del_ack, del_found,
           h_key, h_value, h_add, h_update, h_del, h_req
  );

  modport slave (
    output in_src, in_dst, in_valid, out_ready, del_key, del_req,
           h_ack, h_found, h_found_value, h_ovf,
    input  in_ready, out_found, out_value, out_new, out_valid, del_ack, del_found,
           h_key, h_value, h_add, h_update, h_del, h_req
  );
endinterface

// File: rtl/hash_learn_tick.sv
// Age-tick generator: prescaler of TICK_CYCLES clocks advancing a wrapping timestamp.
module hash_learn_tick #(
  parameter int TICK_CYCLES = 1000000,
  parameter int VALUEWIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [VALUEWIDTH-1:0] tstamp
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]         r_cnt;
  logic [VALUEWIDTH-1:0] r_tstamp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_tstamp <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt    <= '0;
      r_tstamp <= r_tstamp + VALUEWIDTH'(1);
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign tstamp = r_tstamp;
endmodule

// File: rtl/hash_learn.sv
// Learning engine: per record looks up dst, then adds/refreshes src with the current
// age tick; also serves management deletes. Talks to the hash table one request at a time.
module hash_learn
  import hash_learn_pkg::*;
#(
  parameter int KEYWIDTH    = 20,
  parameter int VALUEWIDTH  = 2,
  parameter int TICK_CYCLES = 1000000,
  parameter int CNTWIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hash_learn_if.master          bus,
  output logic                  ovf,
  output logic [CNTWIDTH-1:0]   learn_count,
  output logic [CNTWIDTH-1:0]   del_count,
  output logic [VALUEWIDTH-1:0] tstamp,
  output state_t                dbg_state
);
  state_t                r_state;
  logic                  r_in_ready;
  logic [KEYWIDTH-1:0]   r_src;
  logic                  r_out_found;
  logic [VALUEWIDTH-1:0] r_out_value;
  logic                  r_out_new;
  logic                  r_out_valid;
  logic                  r_del_ack;
  logic                  r_del_found;
  logic [KEYWIDTH-1:0]   r_h_key;
  logic [VALUEWIDTH-1:0] r_h_value;
  logic                  r_h_add;
  logic                  r_h_update;
  logic                  r_h_del;
  logic                  r_h_req;
  logic                  r_ovf;
  logic [CNTWIDTH-1:0]   r_learn_count;
  logic [CNTWIDTH-1:0]   r_del_count;
  logic [VALUEWIDTH-1:0] w_tstamp;
  logic                  w_learn_new;

  hash_learn_tick #(
    .TICK_CYCLES(TICK_CYCLES),
    .VALUEWIDTH (VALUEWIDTH)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tstamp(w_tstamp)
  );

  // h_ovf is taken as seen on the ack cycle, so an add that overflowed is not new.
  assign w_learn_new = !bus.h_found && !bus.h_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b0;
      r_src         <= '0;
      r_out_found   <= 1'b0;
      r_out_value   <= '0;
      r_out_new     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_del_ack     <= 1'b0;
      r_del_found   <= 1'b0;
      r_h_key       <= '0;
      r_h_value     <= '0;
      r_h_add       <= 1'b0;
      r_h_update    <= 1'b0;
      r_h_del       <= 1'b0;
      r_h_req       <= 1'b0;
      r_ovf         <= 1'b0;
      r_learn_count <= '0;
      r_del_count   <= '0;
    end else begin
      r_ovf     <= bus.h_ovf;
      r_del_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_in_ready) begin
            r_in_ready <= 1'b0;
            if (bus.in_valid) begin
              r_src      <= bus.in_src;
              r_h_key    <= bus.in_dst;
              r_h_value  <= '0;
              r_h_add    <= 1'b0;
              r_h_update <= 1'b0;
              r_h_del    <= 1'b0;
              r_h_req    <= 1'b1;
              r_state    <= ST_LOOKUP;
            end
          // del_ack high means the caller may still be holding the finished del_req.
          end else if (bus.del_req && !r_del_ack) begin
            r_h_key    <= bus.del_key;
            r_h_value  <= '0;
            r_h_add    <= 1'b0;
            r_h_update <= 1'b0;
            r_h_del    <= 1'b1;
            r_h_req    <= 1'b1;
            r_state    <= ST_DEL;
          end else if (bus.in_valid && !r_out_valid) begin
            r_in_ready <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (bus.h_ack) begin
            r_h_req     <= 1'b0;
            r_out_found <= bus.h_found;
            r_out_value <= bus.h_found ? bus.h_found_value : '0;
            r_state     <= ST_LEARN;
          end
        end
        ST_LEARN: begin
          // h_req is low on entry (dropped on the lookup ack), so the learn issues one cycle later.
          if (!r_h_req) begin
            r_h_key    <= r_src;
            r_h_value  <= w_tstamp;
            r_h_add    <= 1'b1;
            r_h_update <= 1'b1;
            r_h_del    <= 1'b0;
            r_h_req    <= 1'b1;
          end else if (bus.h_ack) begin
            r_h_req       <= 1'b0;
            r_h_add       <= 1'b0;
            r_h_update    <= 1'b0;
            r_out_new     <= w_learn_new;
            r_learn_count <= r_learn_count + CNTWIDTH'(w_learn_new);
            r_out_valid   <= 1'b1;
            r_state       <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DEL: begin
          if (bus.h_ack) begin
            r_h_req     <= 1'b0;
            r_h_del     <= 1'b0;
            r_del_ack   <= 1'b1;
            r_del_found <= bus.h_found;
            r_del_count <= r_del_count + CNTWIDTH'(bus.h_found);
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_found = r_out_found;
  assign bus.out_value = r_out_value;
  assign bus.out_new   = r_out_new;
  assign bus.out_valid = r_out_valid;
  assign bus.del_ack   = r_del_ack;
  assign bus.del_found = r_del_found;
  assign bus.h_key     = r_h_key;
  assign bus.h_value   = r_h_value;
  assign bus.h_add     = r_h_add;
  assign bus.h_update  = r_h_update;
  assign bus.h_del     = r_h_del;
  assign bus.h_req     = r_h_req;
  assign ovf           = r_ovf;
  assign learn_count   = r_learn_count;
  assign del_count     = r_del_count;
  assign tstamp        = w_tstamp;
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_hash_learn.sv
// Bench for hash_learn: behavioural 8-entry table responder plus a key->timestamp
// reference of expected record/delete outcomes.
module tb_hash_learn;
  import hash_learn_pkg::*;

  localparam int KW   = 20;
  localparam int VW   = 2;
  localparam int TICK = 40;
  localparam int CW   = 16;
  localparam int CAP  = 8;

  logic          clk;
  logic          reset;
  logic          ovf;
  logic [CW-1:0] learn_count;
  logic [CW-1:0] del_count;
  logic [VW-1:0] tstamp;
  state_t        dbg_state;

  hash_learn_if #(.KEYWIDTH(KW), .VALUEWIDTH(VW)) bus ();

  hash_learn #(
    .KEYWIDTH(KW), .VALUEWIDTH(VW), .TICK_CYCLES(TICK), .CNTWIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .ovf(ovf), .learn_count(learn_count),
    .del_count(del_count), .tstamp(tstamp), .dbg_state(dbg_state)
  );

  // clock / reset / cycle count since reset release
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int model_ts(input int c);
    return (c / TICK) % (1 << VW);
  endfunction

  // scoreboard counters
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // reference model of table contents as the engine should leave them
  int ref_tab[int];
  bit ovf_m;
  int exp_learn_cnt;
  int exp_del_cnt;
  int last_learn_ts;

  // behavioural table responder
  int  tab[int];
  bit  t_ovf;
  bit  pend;
  int  busy, dly, p_key, p_val;
  logic [2:0] p_op;
  bit  t_found;

  initial begin
    bus.h_ack = 1'b0; bus.h_found = 1'b0; bus.h_found_value = '0; bus.h_ovf = 1'b0;
    pend = 0; busy = 0; dly = 0; t_ovf = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tab.delete(); t_ovf = 0; pend = 0; busy = 0;
        bus.h_ack = 1'b0; bus.h_ovf = 1'b0;
      end else if (bus.h_ack) begin
        bus.h_ack = 1'b0;
        chk("req_low_after_ack", bus.h_req, 0);
        busy = $urandom_range(1, 4);
      end else if (busy > 0) begin
        busy--;
      end else if (bus.h_req) begin
        if (!pend) begin
          pend = 1; p_key = bus.h_key; p_val = bus.h_value;
          p_op = {bus.h_add, bus.h_update, bus.h_del};
          dly = $urandom_range(0, 3);
        end
        if (dly > 0) dly--;
        else begin
          chk("req_stable", {bus.h_key, bus.h_value, bus.h_add, bus.h_update, bus.h_del},
              {p_key[KW-1:0], p_val[VW-1:0], p_op});
          t_found = tab.exists(p_key);
          bus.h_found = t_found;
          bus.h_found_value = t_found ? VW'(tab[p_key]) : VW'($urandom_range(0, 3));
          if (p_op[0]) tab.delete(p_key);
          else if (p_op[2]) begin
            if (t_found || tab.num() < CAP) tab[p_key] = p_val;
            else t_ovf = 1;
          end
          bus.h_ovf = t_ovf;
          bus.h_ack = 1'b1;
          pend = 0;
        end
      end
    end
  end

  // learn requests must carry the tick that was current when they were issued
  bit prev_req;
  always @(negedge clk) begin
    if (reset) prev_req = 0;
    else begin
      if (bus.h_req && !prev_req && bus.h_add) begin
        last_learn_ts = model_ts(cyc - 1);
        chk("learn_value", bus.h_value, last_learn_ts);
      end
      prev_req = bus.h_req;
    end
  end

  // driver tasks
  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.del_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ref_tab.delete(); ovf_m = 0; exp_learn_cnt = 0; exp_del_cnt = 0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_h_req", bus.h_req, 0);
    chk("rst_del_ack", bus.del_ack, 0);
    chk("rst_counts", {learn_count, del_count}, 0);
    chk("rst_tstamp_ovf", {tstamp, ovf}, 0);
    chk("rst_state", dbg_state, ST_IDLE);
  endtask

  task automatic wait_ts(input int target);
    bit ok = 0;
    for (int i = 0; i < 8 * TICK && !ok; i++) begin
      if (model_ts(cyc) == target) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk("wait_ts_timeout", 0, 1);
  endtask

  task automatic run_record(input int src, input int dst, input int hold);
    int exp_found, exp_val, exp_new;
    bit ok;
    exp_found = ref_tab.exists(dst);
    exp_val   = exp_found ? ref_tab[dst] : 0;
    exp_new   = (!ref_tab.exists(src) && ref_tab.num() < CAP && !ovf_m);
    @(negedge clk);
    bus.in_src = src; bus.in_dst = dst; bus.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.in_ready) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("in_ready_pulse", bus.in_ready, 0);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.out_valid) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    if (exp_new) exp_learn_cnt++;
    chk("out_found", bus.out_found, exp_found);
    chk("out_value", bus.out_value, exp_val);
    chk("out_new", bus.out_new, exp_new);
    chk("learn_count", learn_count, exp_learn_cnt % (1 << CW));
    chk("tstamp", tstamp, model_ts(cyc));
    if (hold > 0) begin
      bus.in_src = src + 1; bus.in_dst = dst; bus.in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_out_valid", bus.out_valid, 1);
        chk("hold_in_ready", bus.in_ready, 0);
        chk("hold_h_req", bus.h_req, 0);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    if (ref_tab.exists(src) || ref_tab.num() < CAP) ref_tab[src] = last_learn_ts;
    else ovf_m = 1;
  endtask

  task automatic run_del(input int key, input bit with_rec, input int src, input int dst);
    int exp_found;
    bit ok, saw_ready;
    exp_found = ref_tab.exists(key);
    @(negedge clk);
    bus.del_key = key; bus.del_req = 1'b1;
    if (with_rec) begin
      bus.in_src = src; bus.in_dst = dst; bus.in_valid = 1'b1;
    end
    ok = 0; saw_ready = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.in_ready) saw_ready = 1;
      if (bus.del_ack) ok = 1;
      else @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      chk("del_ack_timeout", 0, 1);
      bus.del_req = 1'b0;
      return;
    end
    if (exp_found) exp_del_cnt++;
    chk("del_first", saw_ready, 0);
    chk("del_found", bus.del_found, exp_found);
    chk("del_count", del_count, exp_del_cnt % (1 << CW));
    @(negedge clk);
    chk("del_ack_pulse", bus.del_ack, 0);
    bus.del_req = 1'b0;
    @(negedge clk);
    chk("del_no_repeat", bus.h_req, 0);
    ref_tab.delete(key);
  endtask

  // watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // directed steps and randomized mix
  initial begin
    reset = 1'b1;
    bus.in_src = '0; bus.in_dst = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.del_key = '0; bus.del_req = 1'b0;
    last_learn_ts = 0;
    reset_dut();

    run_record(5, 9, 0);
    wait_ts(2);
    run_record(9, 5, 0);
    wait_ts(3);
    run_record(5, 1, 0);
    run_record(2, 5, 0);

    run_record(7, 9, 20);
    run_record(8, 7, 0);

    run_del(5, 1'b1, 11, 2);
    run_record(11, 2, 0);
    run_del(5, 1'b0, 0, 0);

    repeat (24) begin
      if ($urandom_range(0, 3) == 0) run_del($urandom_range(0, 11), 1'b0, 0, 0);
      else run_record($urandom_range(0, 11), $urandom_range(0, 11), 0);
    end

    reset_dut();
    for (int i = 0; i < CAP; i++) run_record(100 + i, $urandom_range(90, 110), 0);
    run_record(300, 100, 0);
    chk("ovf_full", ovf, 1);
    chk("learn_count_full", learn_count, CAP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
